// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shifter constants and state encoding
package shift_pkg;

    localparam int WIDTH  = 32;
    localparam int SHW    = 5;
    localparam int STRIDE = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_t;

endpackage

// File: rtl/shr_step.sv
// rtl/shr_step.sv - one right-shift step of the working register (1 or STRIDE positions)
module shr_step
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] work,
    input  logic             fill,
    input  logic             big,
    output logic [WIDTH-1:0] next
);

    // Select a wide stride step or a single-bit step, fill bits entering at the top
    always_comb begin
        next = {fill, work[WIDTH-1:1]};
        if (big) begin
            next = {{STRIDE{fill}}, work[WIDTH-1:STRIDE]};
        end
    end

endmodule

// File: rtl/shr_iterative.sv
// rtl/shr_iterative.sv - multicycle logical/arithmetic right shifter (option: SHR_STRIDE4_EN)
module shr_iterative
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int SHW   = shift_pkg::SHW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   sh_amt,
    input  logic             arith,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             busy
);

    shift_state_t     state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             fill;

    logic             big;
    logic [SHW-1:0]   step_amt;
    logic [SHW-1:0]   cnt_next;
    logic [WIDTH-1:0] work_next;

`ifdef SHR_STRIDE4_EN
    assign big = (cnt >= SHW'(STRIDE));
`else
    assign big = 1'b0;
`endif

    assign step_amt = big ? SHW'(STRIDE) : SHW'(1);
    assign cnt_next = cnt - step_amt;

    shr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .work (work),
        .fill (fill),
        .big  (big),
        .next (work_next)
    );

    // Control FSM: accept a request in IDLE, step the working register in SHIFT,
    // publish the result only on the completing edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            out   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            work  <= '0;
            cnt   <= '0;
            fill  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= in;
                        cnt   <= sh_amt;
                        fill  <= arith & in[WIDTH-1];
                        valid <= 1'b0;
                        if (sh_amt == '0) begin
                            out   <= in;
                            valid <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt_next;
                    if (cnt_next == '0) begin
                        out   <= work_next;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shr_iterative.sv
// tb/tb_shr_iterative.sv - randomized self-checking bench for shr_iterative
module tb_shr_iterative;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] din;
    logic [4:0]  sh_amt;
    logic        arith;
    logic [31:0] dout;
    logic        valid;
    logic        busy;

    int n_vec;
    int n_err;
    logic [31:0] last_out;

    shr_iterative dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .in     (din),
        .sh_amt (sh_amt),
        .arith  (arith),
        .out    (dout),
        .valid  (valid),
        .busy   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shr(input logic [31:0] a, input int s, input logic b);
        if (b) return 32'($signed(a) >>> s);
        return a >> s;
    endfunction

    function automatic int ref_lat(input int s);
`ifdef SHR_STRIDE4_EN
        return (s / 4) + (s % 4);
`else
        return s;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One request; noise=1 pulses random ignored starts and garbage inputs while busy
    task automatic run(input logic [31:0] a, input int s, input logic b, input bit noise);
        int n;
        bit held_ok;
        logic [31:0] exp;
        exp = ref_shr(a, s, b);
        start = 1'b1; din = a; sh_amt = 5'(s); arith = b;
        tick();
        start = 1'b0; din = $urandom; sh_amt = 5'($urandom); arith = 1'($urandom);
        if (s == 0) begin
            check("busy_zero_shift", {31'b0, busy}, 32'd0);
        end else begin
            check("valid_drop_e0", {31'b0, valid}, 32'd0);
            check("busy_e0", {31'b0, busy}, 32'd1);
        end
        n = 0;
        held_ok = 1'b1;
        while (!valid && n < 40) begin
            if (dout !== last_out) held_ok = 1'b0;
            if (noise) begin
                start = 1'($urandom);
                din = $urandom;
                sh_amt = 5'($urandom);
            end
            tick();
            n++;
        end
        start = 1'b0;
        check("latency", 32'(n), 32'(ref_lat(s)));
        check("result", dout, exp);
        check("out_held", {31'b0, held_ok}, 32'd1);
        check("busy_done", {31'b0, busy}, 32'd0);
        last_out = exp;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        last_out = '0;
        reset = 1'b1; start = 1'b1; din = 32'hFFFF_FFFF; sh_amt = 5'd3; arith = 1'b0;
        tick(); tick(); tick();
        check("rst_out", dout, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();

        run(32'h8000_0000, 4, 1'b0, 1'b0);
        run(32'h8000_0000, 31, 1'b1, 1'b0);
        run(32'hDEAD_BEEF, 0, 1'b0, 1'b0);

        // Second start at E0+3 must be ignored
        start = 1'b1; din = 32'h0000_00F0; sh_amt = 5'd8; arith = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; din = 32'h1; sh_amt = 5'd0;
        tick();
        start = 1'b0;
        begin
            int n;
            n = 3;
            while (!valid && n < 40) begin
                tick();
                n++;
            end
            check("busy_start_lat", 32'(n), 32'(ref_lat(8)));
            check("busy_start_out", dout, 32'h0);
            last_out = 32'h0;
        end

        // Back-to-back: next start issued the cycle valid rises
        run(32'h7FFF_FFFF, 1, 1'b1, 1'b0);
        run(32'hC000_0001, 3, 1'b1, 1'b0);

        // Reset mid-shift aborts with no later result
        start = 1'b1; din = 32'h1234_5678; sh_amt = 5'd20; arith = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick(); tick();
        check("midrst_out", dout, 32'd0);
        check("midrst_valid", {31'b0, valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        begin
            bit saw_valid;
            saw_valid = 1'b0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (valid) saw_valid = 1'b1;
            end
            check("midrst_no_valid", {31'b0, saw_valid}, 32'd0);
        end
        last_out = 32'd0;

        for (int k = 0; k < 150; k++) begin
            int gap;
            run($urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'b1);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            if (gap > 0) check("hold_idle", dout, last_out);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
